// File: rtl/instr_encoder.sv
// Field-level instruction encoder: builds ARMv4-subset words (DP/MEM/BR) and
// writes them sequentially into instruction memory starting at word 0.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [3:0]        req_cond,
    input  logic [3:0]        req_cmd,
    input  logic              req_s,
    input  logic              req_i,
    input  logic              req_load,
    input  logic [3:0]        req_rn,
    input  logic [3:0]        req_rd,
    input  logic [3:0]        req_rm,
    input  logic [1:0]        req_sh,
    input  logic [4:0]        req_shamt,
    input  logic [23:0]       req_imm,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_ENC    = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d, err_q, err_d, im_we_q, im_we_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;

    logic [1:0]  kind_q, sh_q;
    logic [3:0]  cond_q, cmd_q, rn_q, rd_q, rm_q;
    logic        s_q, i_q, load_q;
    logic [4:0]  shamt_q;
    logic [23:0] imm_q;

    logic [31:0] enc_word_s;
    logic        legal_s;

    // Only the commands the decoder fully defines; MOV needs ROR register form, CMP needs S.
    function automatic logic dp_legal(input logic [3:0] cmd, input logic i, input logic s,
                                      input logic [1:0] sh);
        logic ok;
        case (cmd)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1100, 4'b1111: ok = 1'b1;
            4'b1101: ok = (i == 1'b0) && (sh == 2'b11);
            4'b1010: ok = (s == 1'b1);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] encode(
        input logic [1:0] kind, input logic [3:0] cond, input logic [3:0] cmd,
        input logic s, input logic i, input logic load,
        input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
        input logic [1:0] sh, input logic [4:0] shamt, input logic [23:0] imm);
        logic [31:0] w;
        logic [11:0] src2;
        logic [3:0]  rd_eff;
        src2   = i ? imm[11:0] : {shamt, sh, 1'b0, rm};
        rd_eff = (cmd == 4'b1010) ? 4'b0000 : rd;
        case (kind)
            2'b00:   w = {cond, 2'b00, i, cmd, s, rn, rd_eff, src2};
            2'b01:   w = {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, load, rn, rd, imm[11:0]};
            2'b10:   w = {cond, 4'b1010, imm};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    assign enc_word_s = encode(kind_q, cond_q, cmd_q, s_q, i_q, load_q, rn_q, rd_q, rm_q,
                               sh_q, shamt_q, imm_q);
    assign legal_s    = (kind_q != 2'b00) || dp_legal(cmd_q, i_q, s_q, sh_q);

    // Request field capture on handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q <= 2'b00; cond_q <= 4'h0; cmd_q <= 4'h0; s_q <= 1'b0; i_q <= 1'b0;
            load_q <= 1'b0; rn_q <= 4'h0; rd_q <= 4'h0; rm_q <= 4'h0; sh_q <= 2'b00;
            shamt_q <= 5'd0; imm_q <= 24'h00_0000;
        end else if (state_q == S_ACCEPT && req_valid) begin
            kind_q <= req_kind; cond_q <= req_cond; cmd_q <= req_cmd; s_q <= req_s;
            i_q <= req_i; load_q <= req_load; rn_q <= req_rn; rd_q <= req_rd;
            rm_q <= req_rm; sh_q <= req_sh; shamt_q <= req_shamt; imm_q <= req_imm;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_ACCEPT;
                    count_d    = {(ADDR_W+1){1'b0}};
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = 2'b00;
                    im_addr_d  = {ADDR_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_ACCEPT: begin
                if (req_valid && req_kind == 2'b11) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (req_valid) begin
                    state_d = S_ENC;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_ENC: begin
                im_wdata_d = enc_word_s;
                if (!legal_s) begin
                    state_d    = S_ERROR;
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                end else if (count_q == DEPTH_C) begin
                    state_d    = S_ERROR;
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                end else begin
                    state_d   = S_WRITE;
                    im_we_d   = 1'b1;
                    im_addr_d = count_q[ADDR_W-1:0];
                end
            end
            S_WRITE: begin
                count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
                state_d = S_ACCEPT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= {(ADDR_W+1){1'b0}};
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            im_we_q    <= 1'b0;
            im_addr_q  <= {ADDR_W{1'b0}};
            im_wdata_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
        end
    end

    assign req_ready = (state_q == S_ACCEPT);
    assign busy      = (state_q == S_ACCEPT) || (state_q == S_ENC) || (state_q == S_WRITE);
    assign im_we     = im_we_q;
    assign im_addr   = im_addr_q;
    assign im_wdata  = im_wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a 64-word instance for encoding/session
// checks and a 4-word instance sharing the same stimulus for overflow checks.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, start, req_valid;
    logic [1:0]  req_kind, req_sh;
    logic [3:0]  req_cond, req_cmd, req_rn, req_rd, req_rm;
    logic        req_s, req_i, req_load;
    logic [4:0]  req_shamt;
    logic [23:0] req_imm;

    logic        req_ready, im_we, busy, done, err;
    logic [5:0]  im_addr;
    logic [31:0] im_wdata;
    logic [1:0]  err_code;
    logic [6:0]  count;

    logic        req_ready2, im_we2, busy2, done2, err2;
    logic [1:0]  im_addr2;
    logic [31:0] im_wdata2;
    logic [1:0]  err_code2;
    logic [2:0]  count2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_cond(req_cond), .req_cmd(req_cmd), .req_s(req_s),
        .req_i(req_i), .req_load(req_load), .req_rn(req_rn), .req_rd(req_rd), .req_rm(req_rm),
        .req_sh(req_sh), .req_shamt(req_shamt), .req_imm(req_imm), .im_we(im_we),
        .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .count(count)
    );

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .req_valid(req_valid), .req_ready(req_ready2),
        .req_kind(req_kind), .req_cond(req_cond), .req_cmd(req_cmd), .req_s(req_s),
        .req_i(req_i), .req_load(req_load), .req_rn(req_rn), .req_rd(req_rd), .req_rm(req_rm),
        .req_sh(req_sh), .req_shamt(req_shamt), .req_imm(req_imm), .im_we(im_we2),
        .im_addr(im_addr2), .im_wdata(im_wdata2), .busy(busy2), .done(done2), .err(err2),
        .err_code(err_code2), .count(count2)
    );

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] k, input logic [3:0] cmd, input logic s,
                           input logic i, input logic ld, input logic [3:0] rn,
                           input logic [3:0] rd, input logic [3:0] rm, input logic [1:0] sh,
                           input logic [4:0] sa, input logic [23:0] imm);
        req_kind = k; req_cond = 4'hE; req_cmd = cmd; req_s = s; req_i = i; req_load = ld;
        req_rn = rn; req_rd = rd; req_rm = rm; req_sh = sh; req_shamt = sa; req_imm = imm;
    endtask

    // Present the request for one cycle; returns sampled in the cycle after handshake.
    task automatic fire();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_end();
        set_req(2'b11, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 5'd0, 24'h0);
        fire();
    endtask

    task automatic send_add();
        set_req(2'b00, 4'b0100, 1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 4'd3, 2'b00, 5'd0, 24'h0);
        fire();
    endtask

    // Called right after fire(): checks ENC, WRITE, and return to ACCEPT on the 64-word DUT.
    task automatic expect_write(input string tag, input logic [5:0] a, input logic [31:0] w);
        chk({tag, " enc_we"}, 64'(im_we), 64'd0);
        tick();
        chk({tag, " we"}, 64'(im_we), 64'd1);
        chk({tag, " addr"}, 64'(im_addr), 64'(a));
        chk({tag, " wdata"}, 64'(im_wdata), 64'(w));
        tick();
        chk({tag, " ready"}, 64'(req_ready), 64'd1);
        chk({tag, " we_off"}, 64'(im_we), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ready"}, 64'(req_ready), 64'd0);
        chk({tag, " we"}, 64'(im_we), 64'd0);
        chk({tag, " addr"}, 64'(im_addr), 64'd0);
        chk({tag, " wdata"}, 64'(im_wdata), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " err"}, 64'(err), 64'd0);
        chk({tag, " code"}, 64'(err_code), 64'd0);
        chk({tag, " count"}, 64'(count), 64'd0);
    endtask

    task automatic expect_illegal(input string tag);
        chk({tag, " enc_we"}, 64'(im_we), 64'd0);
        tick();
        chk({tag, " we"}, 64'(im_we), 64'd0);
        chk({tag, " err"}, 64'(err), 64'd1);
        chk({tag, " code"}, 64'(err_code), 64'd1);
        chk({tag, " ready"}, 64'(req_ready), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        tick();
        chk({tag, " we_late"}, 64'(im_we), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; req_valid = 1'b0;
        set_req(2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 5'd0, 24'h0);
        tick(); tick();
        chk_reset_vals("rst");
        chk("rst count2", 64'(count2), 64'd0);

        // start and reset together: reset wins
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_start ready", 64'(req_ready), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle ready", 64'(req_ready), 64'd0);

        // ADD R1,R2,R3
        pulse_start();
        chk("start ready", 64'(req_ready), 64'd1);
        chk("start busy", 64'(busy), 64'd1);
        send_add();
        expect_write("add", 6'd0, 32'hE082_1003);
        chk("add count", 64'(count), 64'd1);
        send_end();
        chk("end1 done", 64'(done), 64'd1);
        chk("end1 busy", 64'(busy), 64'd0);
        chk("end1 ready", 64'(req_ready), 64'd0);

        // Stream of five in a fresh session
        pulse_start();
        chk("s5 count0", 64'(count), 64'd0);
        chk("s5 done0", 64'(done), 64'd0);
        set_req(2'b00, 4'b0010, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 5'd0, 24'h000001);
        fire(); expect_write("sub", 6'd0, 32'hE240_0001);
        set_req(2'b00, 4'b1010, 1'b1, 1'b1, 1'b0, 4'd1, 4'd7, 4'd0, 2'b00, 5'd0, 24'h000000);
        fire(); expect_write("cmp", 6'd1, 32'hE351_0000);
        set_req(2'b01, 4'h0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd2, 4'd0, 2'b00, 5'd0, 24'h000004);
        fire(); expect_write("ldr", 6'd2, 32'hE593_2004);
        set_req(2'b01, 4'h0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd2, 4'd0, 2'b00, 5'd0, 24'h000004);
        fire(); expect_write("str", 6'd3, 32'hE583_2004);
        set_req(2'b10, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 5'd0, 24'h000002);
        fire(); expect_write("b", 6'd4, 32'hEA00_0002);
        send_end();
        chk("s5 done", 64'(done), 64'd1);
        chk("s5 err", 64'(err), 64'd0);
        chk("s5 count", 64'(count), 64'd5);

        // Illegal DP encodings, each in a fresh session
        pulse_start();
        set_req(2'b00, 4'b1101, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 2'b00, 5'd4, 24'h0);
        fire(); expect_illegal("ill_mov");
        pulse_start();
        chk("ill clr err", 64'(err), 64'd0);
        chk("ill clr code", 64'(err_code), 64'd0);
        set_req(2'b00, 4'b1010, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 2'b00, 5'd0, 24'h0);
        fire(); expect_illegal("ill_cmp");
        pulse_start();
        set_req(2'b00, 4'b0011, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 2'b00, 5'd0, 24'h0);
        fire(); expect_illegal("ill_0011");

        // MOV R0,R1,ROR #4
        pulse_start();
        set_req(2'b00, 4'b1101, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 2'b11, 5'd4, 24'h0);
        fire(); expect_write("mov_ror", 6'd0, 32'hE1A0_0261);
        send_end();

        // Overflow on the 4-word instance
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            send_add();
            tick();
            chk("ovf we", 64'(im_we2), 64'd1);
            chk("ovf addr", 64'(im_addr2), 64'(k));
            chk("ovf wdata", 64'(im_wdata2), 64'hE082_1003);
            tick();
        end
        chk("ovf count4", 64'(count2), 64'd4);
        send_add();
        chk("ovf5 enc_we", 64'(im_we2), 64'd0);
        tick();
        chk("ovf5 we", 64'(im_we2), 64'd0);
        chk("ovf5 err", 64'(err2), 64'd1);
        chk("ovf5 code", 64'(err_code2), 64'd2);
        chk("ovf5 count", 64'(count2), 64'd4);
        chk("ovf5 ready", 64'(req_ready2), 64'd0);
        tick();
        send_end();
        chk("ovf end ignored", 64'(done2), 64'd0);

        // Fresh start after overflow writes at addr 0; full memory then END gives DONE
        pulse_start();
        chk("ovf restart err", 64'(err2), 64'd0);
        for (int k = 0; k < 4; k++) begin
            send_add();
            tick();
            chk("fill addr", 64'(im_addr2), 64'(k));
            chk("fill we", 64'(im_we2), 64'd1);
            tick();
        end
        send_end();
        chk("full end done", 64'(done2), 64'd1);
        chk("full end err", 64'(err2), 64'd0);
        chk("full end count", 64'(count2), 64'd4);

        // Reset during ENC drops the pending write
        pulse_start();
        send_add();
        chk("mid enc busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        chk_reset_vals("mid_rst");
        reset = 1'b0;
        tick();
        chk("mid_rst we_late", 64'(im_we), 64'd0);
        chk("mid_rst idle", 64'(req_ready), 64'd0);
        pulse_start();
        send_add();
        expect_write("post_rst", 6'd0, 32'hE082_1003);
        chk("post_rst count", 64'(count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
